// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID skid stage register.
//   state_e        : FSM encoding (EMPTY=0, ONE=1, FULL=2)
//   XLEN_DEFAULT   : default datapath width
//   EPOCH_W_DEFAULT: default width of the flush epoch counter
//   payload_w()    : packed entry width, 4*XLEN + 1 + EPOCH_W
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int XLEN_DEFAULT    = 32;
  localparam int EPOCH_W_DEFAULT = 2;

  // An entry holds inst, pc, pc4, pre_taken, pre_bjpc and its epoch tag.
  function automatic int payload_w(input int xlen, input int epoch_w);
    return 4 * xlen + 1 + epoch_w;
  endfunction

endpackage

// File: rtl/pipe_if_id_skid_reg_if.sv
// Bundle of the IF-side and ID-side handshake/data signals of the IF/ID stage.
//   master : the surrounding pipeline (fetch drives if_*/flush, decode drives id_ready)
//   slave  : the skid register itself
interface pipe_if_id_skid_reg_if #(
  parameter int XLEN    = pipe_pkg::XLEN_DEFAULT,
  parameter int EPOCH_W = pipe_pkg::EPOCH_W_DEFAULT
) ();

  logic               if_valid;
  logic               if_ready;
  logic [XLEN-1:0]    inst_in;
  logic [XLEN-1:0]    pc_in;
  logic [XLEN-1:0]    pc4_in;
  logic               pre_taken_in;
  logic [XLEN-1:0]    pre_bjpc_in;
  logic               flush;
  logic               id_valid;
  logic               id_ready;
  logic [XLEN-1:0]    inst_out;
  logic [XLEN-1:0]    pc_out;
  logic [XLEN-1:0]    pc4_out;
  logic               pre_taken_out;
  logic [XLEN-1:0]    pre_bjpc_out;
  logic [EPOCH_W-1:0] epoch_out;
  logic [EPOCH_W-1:0] epoch_cur;

  modport master (
    output if_valid, inst_in, pc_in, pc4_in, pre_taken_in, pre_bjpc_in, flush, id_ready,
    input  if_ready, id_valid, inst_out, pc_out, pc4_out, pre_taken_out, pre_bjpc_out,
           epoch_out, epoch_cur
  );

  modport slave (
    input  if_valid, inst_in, pc_in, pc4_in, pre_taken_in, pre_bjpc_in, flush, id_ready,
    output if_ready, id_valid, inst_out, pc_out, pc4_out, pre_taken_out, pre_bjpc_out,
           epoch_out, epoch_cur
  );

endinterface

// File: rtl/pipe_payload_reg.sv
// Enable-gated payload register with synchronous active-high reset.
//   clk, rst_n : clock, synchronous reset (active-high)
//   en         : load d on the next edge
//   d, q       : W-bit payload in/out
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_if_id_skid_reg.sv
// IF/ID stage register with valid/ready handshake and a 2-entry skid buffer.
// entry0 is the head and drives the *_out signals; entry1 is the skid slot.
// if_ready is registered so decode stalls never reach fetch combinationally.
// flush squashes all held entries and bumps the epoch tag stored per entry.
//   clk, rst_n : clock, synchronous reset (active-high despite the name)
//   bus        : slave side of pipe_if_id_skid_reg_if (handshakes, payloads,
//                flush, epoch_out, epoch_cur)
// Optional macro PIPE_IF_ID_PERF_EN adds saturating counters:
//   stall_cnt[31:0] : cycles with id_valid & !id_ready
//   flush_cnt[15:0] : number of flushes
module pipe_if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int EPOCH_W = EPOCH_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  pipe_if_id_skid_reg_if.slave bus
`ifdef PIPE_IF_ID_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int PW = payload_w(XLEN, EPOCH_W);

  state_e             state_q, state_d;
  logic               if_ready_q, if_ready_d;
  logic               id_valid_q, id_valid_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  logic               push, pop;
  logic               en0, en1, sel_skid;
  logic [PW-1:0]      in_payload, d0, entry0_q, entry1_q;

  assign push = bus.if_valid & if_ready_q;
  assign pop  = id_valid_q & bus.id_ready;

  // Incoming entry is tagged with the epoch current at its write edge.
  assign in_payload = {bus.inst_in, bus.pc_in, bus.pc4_in, bus.pre_taken_in,
                       bus.pre_bjpc_in, epoch_q};

  // entry0 refills from the skid when draining FULL, otherwise from fetch.
  assign d0 = sel_skid ? entry1_q : in_payload;

  always_comb begin
    state_d  = state_q;
    epoch_d  = epoch_q;
    en0      = 1'b0;
    en1      = 1'b0;
    sel_skid = 1'b0;
    if (bus.flush) begin
      // Flush wins over push/pop; payload registers keep stale data.
      state_d = ST_EMPTY;
      epoch_d = epoch_q + 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            en0     = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_d = ST_FULL;
            en1     = 1'b1;
          end else if (pop && !push) begin
            state_d = ST_EMPTY;
          end else if (push && pop) begin
            en0 = 1'b1;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d  = ST_ONE;
            en0      = 1'b1;
            sel_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    id_valid_d = (state_d != ST_EMPTY);
    if_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_EMPTY;
      id_valid_q <= 1'b0;
      if_ready_q <= 1'b1;
      epoch_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      if_ready_q <= if_ready_d;
      epoch_q    <= epoch_d;
    end
  end

  pipe_payload_reg #(.W(PW)) u_entry0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en0),
    .d     (d0),
    .q     (entry0_q)
  );

  pipe_payload_reg #(.W(PW)) u_entry1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en1),
    .d     (in_payload),
    .q     (entry1_q)
  );

  assign {bus.inst_out, bus.pc_out, bus.pc4_out, bus.pre_taken_out,
          bus.pre_bjpc_out, bus.epoch_out} = entry0_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.epoch_cur = epoch_q;

`ifdef PIPE_IF_ID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_valid_q && !bus.id_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bus.flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
